// File: rtl/glitc_intercom_pkg.sv
// Shared types and constants for the GLITC intercom command scheduler.
// State encoding, SYNC word and field widths used by every file below.
package glitc_intercom_pkg;

  localparam int CMD_W = 5;
  localparam int DAT_W = 8;
  localparam int PWR_W = 11;
  localparam int COR_W = 5;
  localparam int ENT_W = CMD_W + DAT_W;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [CMD_W-1:0] SYNC_CMD = 5'h04;
  localparam logic [DAT_W-1:0] SYNC_DAT = 8'hED;

endpackage

// File: rtl/glitc_intercom_cmd_fifo.sv
// Synchronous command FIFO with registered read data and registered ready.
// Ready is computed from next-cycle occupancy so it never admits a push when full.
module glitc_intercom_cmd_fifo
  import glitc_intercom_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en_nxt,
  input  logic             i_push,
  input  logic [ENT_W-1:0] i_wdat,
  input  logic             i_pop,
  output logic [ENT_W-1:0] o_rdat,
  output logic             o_empty,
  output logic             o_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic [ENT_W-1:0] r_rdat;
  logic             r_ready;
  logic [AW:0]      w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_push && !i_pop)
      w_cnt_nxt = r_cnt + 1'b1;
    else if (!i_push && i_pop)
      w_cnt_nxt = r_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_push)
      r_mem[r_wptr] <= i_wdat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_rdat  <= '0;
      r_ready <= 1'b0;
    end else begin
      if (i_push)
        r_wptr <= r_wptr + 1'b1;
      if (i_pop) begin
        r_rdat <= r_mem[r_rptr];
        r_rptr <= r_rptr + 1'b1;
      end
      r_cnt   <= w_cnt_nxt;
      r_ready <= i_en_nxt && (w_cnt_nxt != (AW+1)'(DEPTH));
    end
  end

  assign o_rdat  = r_rdat;
  assign o_empty = (r_cnt == '0);
  assign o_ready = r_ready;

endmodule

// File: rtl/glitc_intercom_cmd_sched.sv
// GLITC intercom command scheduler: HOLD -> TRAIN -> RUN link bring-up.
// Optional periodic SYNC in RUN is enabled by defining INTERCOM_SYNC_GEN_EN.
module glitc_intercom_cmd_sched
  import glitc_intercom_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int HOLD_CYCLES  = 16,
  parameter int TRAIN_CYCLES = 64,
  parameter int SYNC_PERIOD  = 1024
) (
  input  logic        sysclk_i,
  input  logic        rst_n_i,
  input  logic        cmd_valid_i,
  input  logic [4:0]  cmd_i,
  input  logic [7:0]  cmd_dat_i,
  output logic        cmd_ready_o,
  input  logic [10:0] power_i,
  input  logic [4:0]  corr_i,
  output logic        do_cmd_o,
  output logic [4:0]  cmd_o,
  output logic [7:0]  cmd_dat_o,
  output logic [10:0] power_o,
  output logic [4:0]  corr_o,
  output logic [3:0]  en_o,
  output logic        data_lost_o,
  output logic [1:0]  state_o
);

  localparam int CMAX = (HOLD_CYCLES > TRAIN_CYCLES) ?
                        HOLD_CYCLES : TRAIN_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HOLD_END  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TRAIN_END = CW'(TRAIN_CYCLES - 1);

  state_e           r_state;
  logic [1:0]       r_rst_sync;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_en;
  logic             r_do_cmd;
  logic [CMD_W-1:0] r_cmd;
  logic [DAT_W-1:0] r_dat;
  logic [PWR_W-1:0] r_pw_s1;
  logic [COR_W-1:0] r_cr_s1;
  logic [PWR_W-1:0] r_pw;
  logic [COR_W-1:0] r_cr;
  logic             r_lost;
  logic             r_hv;

  logic             w_go;
  logic             w_run;
  logic             w_run_nxt;
  logic             w_sync_pend;
  logic             w_emit_head;
  logic             w_pop;
  logic             w_push;
  logic             w_empty;
  logic             w_ready;
  logic [ENT_W-1:0] w_head;

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_rst_sync <= 2'b00;
    else
      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_go      = r_rst_sync[1];
  assign w_run     = (r_state == ST_RUN);
  assign w_run_nxt = w_run ||
                     ((r_state == ST_TRAIN) && (r_cnt == TRAIN_END));
  assign w_push    = cmd_valid_i && w_ready;

  // r_hv: a head entry already sits in the FIFO read register
  assign w_emit_head = w_run && r_hv && !w_sync_pend;
  assign w_pop       = w_run && !w_empty && (!r_hv || w_emit_head);

`ifdef INTERCOM_SYNC_GEN_EN
  localparam int SW = $clog2(SYNC_PERIOD + 1);
  logic [SW-1:0] r_sync_cnt;
  logic          r_sync_pend;
  logic          w_wrap;

  assign w_wrap = (r_sync_cnt == SW'(SYNC_PERIOD - 1));

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync_cnt  <= '0;
      r_sync_pend <= 1'b0;
    end else if (w_run) begin
      r_sync_cnt  <= w_wrap ? '0 : r_sync_cnt + 1'b1;
      r_sync_pend <= w_wrap | (r_sync_pend & ~w_run);
    end
  end

  assign w_sync_pend = r_sync_pend;
`else
  assign w_sync_pend = 1'b0 && (SYNC_PERIOD != 0);
`endif

  glitc_intercom_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (sysclk_i),
    .rst_n    (rst_n_i),
    .i_en_nxt (w_run_nxt),
    .i_push   (w_push),
    .i_wdat   ({cmd_i, cmd_dat_i}),
    .i_pop    (w_pop),
    .o_rdat   (w_head),
    .o_empty  (w_empty),
    .o_ready  (w_ready)
  );

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_HOLD;
      r_cnt    <= '0;
      r_en     <= '0;
      r_do_cmd <= 1'b0;
      r_cmd    <= '0;
      r_dat    <= '0;
      r_pw_s1  <= '0;
      r_cr_s1  <= '0;
      r_pw     <= '0;
      r_cr     <= '0;
      r_lost   <= 1'b0;
      r_hv     <= 1'b0;
    end else begin
      r_pw_s1 <= power_i;
      r_cr_s1 <= corr_i;
      r_lost  <= 1'b0;
      if (w_pop)
        r_hv <= 1'b1;
      else if (w_emit_head)
        r_hv <= 1'b0;
      unique case (r_state)
        ST_HOLD: begin
          r_pw <= r_pw_s1;
          r_cr <= r_cr_s1;
          if (w_go) begin
            if (r_cnt == HOLD_END) begin
              r_state  <= ST_TRAIN;
              r_cnt    <= '0;
              r_en     <= 4'b1111;
              r_do_cmd <= 1'b1;
              r_cmd    <= SYNC_CMD;
              r_dat    <= SYNC_DAT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_TRAIN: begin
          if (r_cnt == TRAIN_END) begin
            r_state  <= ST_RUN;
            r_cnt    <= '0;
            r_do_cmd <= 1'b0;
            r_cmd    <= '0;
            r_dat    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          r_lost <= w_sync_pend | r_hv;
          if (w_sync_pend) begin
            r_do_cmd <= 1'b1;
            r_cmd    <= SYNC_CMD;
            r_dat    <= SYNC_DAT;
          end else if (r_hv) begin
            r_do_cmd <= 1'b1;
            {r_cmd, r_dat} <= w_head;
          end else begin
            r_do_cmd <= 1'b0;
            r_cmd    <= '0;
            r_dat    <= '0;
            r_pw     <= r_pw_s1;
            r_cr     <= r_cr_s1;
          end
        end
        default: r_state <= ST_HOLD;
      endcase
    end
  end

  assign cmd_ready_o = w_ready;
  assign do_cmd_o    = r_do_cmd;
  assign cmd_o       = r_cmd;
  assign cmd_dat_o   = r_dat;
  assign power_o     = r_pw;
  assign corr_o      = r_cr;
  assign en_o        = r_en;
  assign data_lost_o = r_lost;
  assign state_o     = r_state;

endmodule
